// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, controller states and flag-setting decode shared by the hazard controller
package pipe_ctrl_pkg;
   localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR = 4'h2, SLL = 4'h3, SRA = 4'h4, ROR = 4'h5;
   localparam logic [3:0] LW = 4'h8, SW = 4'h9, B = 4'hC, BR = 4'hD, HLT = 4'hF;
   typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
   function automatic logic sets_flags(input logic [3:0] op);
      return op inside {ADD, SUB, XOR, SLL, SRA, ROR};
   endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: stall cycles needed by the decode instruction (0..2)
// FLAG_STALL_EN adds a one-cycle stall for conditional branches behind a flag-setting EX op.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       id_valid,
   input  logic [3:0] id_opcode,
   input  logic [2:0] id_cond,
   input  logic [3:0] id_rs,
   input  logic [3:0] id_rt,
   input  logic [3:0] ex_opcode,
   input  logic       ex_write_reg,
   input  logic [3:0] ex_rd,
   input  logic       mem_write_reg,
   input  logic [3:0] mem_rd,
   output logic [1:0] need
);
   logic br, ex_hit, mem_hit, lw_hit, flag_hit;
`ifdef FLAG_STALL_EN
   assign flag_hit = (br || id_opcode == B) && id_cond != 3'b111 && sets_flags(ex_opcode);
`else
   logic unused_cond;
   assign unused_cond = ^id_cond;
   assign flag_hit = 1'b0;
`endif
   always_comb begin
      br = id_opcode == BR;
      ex_hit = br && ex_write_reg && ex_rd != 4'd0 && ex_rd == id_rs;
      mem_hit = br && mem_write_reg && mem_rd != 4'd0 && mem_rd == id_rs;
      lw_hit = ex_opcode == LW && ex_rd != 4'd0 && (ex_rd == id_rs || ex_rd == id_rt) && !br && id_opcode != B;
      need = !id_valid ? 2'd0 : ex_hit ? 2'd2 : (mem_hit || lw_hit || flag_hit) ? 2'd1 : 2'd0;
   end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/halt-drain FSM for the five-stage pipeline
// Optional FLAG_STALL_EN (see hazard_detect) stalls conditional branches on in-flight flags.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_opcode,
   input  logic [2:0]       id_cond,
   input  logic [3:0]       id_rs,
   input  logic [3:0]       id_rt,
   input  logic [3:0]       ex_opcode,
   input  logic             ex_write_reg,
   input  logic [3:0]       ex_rd,
   input  logic             mem_write_reg,
   input  logic [3:0]       mem_rd,
   input  logic             branch_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);
   state_t state, state_n;
   logic [1:0] cnt, cnt_n, need;
   logic hold, hlt_go;
   hazard_detect u_hd (
      .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond), .id_rs(id_rs), .id_rt(id_rt),
      .ex_opcode(ex_opcode), .ex_write_reg(ex_write_reg), .ex_rd(ex_rd),
      .mem_write_reg(mem_write_reg), .mem_rd(mem_rd), .need(need)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt <= 2'd0;
         stall_count <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (idex_bubble && (state == RUN || state == STALL) && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         RUN: begin
            if (need == 2'd2) begin
               state_n = STALL;
               cnt_n = 2'd1;
            end else if (hlt_go) begin
               state_n = DRAIN;
               cnt_n = 2'(DRAIN_CYCLES - 1);
            end
         end
         STALL: begin
            cnt_n = cnt - 2'd1;
            state_n = cnt == 2'd1 ? RUN : STALL;
         end
         DRAIN: begin
            cnt_n = cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
            state_n = cnt == 2'd0 ? HALTED : DRAIN;
         end
         default: ;
      endcase
   end
   // branch_taken only matters in RUN with no hazard; a stall always wins
   always_comb begin
      hold = state != RUN || need != 2'd0;
      hlt_go = !hold && !branch_taken && id_valid && id_opcode == HLT;
      pc_we = !hold && !hlt_go;
      ifid_we = !hold;
      ifid_flush = (!hold && branch_taken) || hlt_go;
      idex_bubble = hold;
      halted = state == HALTED;
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random stimulus, queue scoreboard against a cycle-level reference model
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;
   localparam int DRAIN = 3;
   localparam int SAT = 15;
   typedef struct {
      logic [4:0] ctl;
      logic [3:0] cnt;
   } exp_t;
   logic clk = 0, rst = 1;
   logic id_valid = 0, ex_write_reg = 0, mem_write_reg = 0, branch_taken = 0;
   logic [3:0] id_opcode = 0, id_rs = 0, id_rt = 0, ex_opcode = 0, ex_rd = 0, mem_rd = 0;
   logic [2:0] id_cond = 0;
   logic pc_we, ifid_we, ifid_flush, idex_bubble, halted;
   logic [3:0] stall_count;
   exp_t q[$];
   int errors = 0, checks = 0;
   int m_stall_left = 0, m_drain_left = 0, m_cnt = 0;
   bit m_halted = 0;
   pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
      .id_rs(id_rs), .id_rt(id_rt), .ex_opcode(ex_opcode), .ex_write_reg(ex_write_reg),
      .ex_rd(ex_rd), .mem_write_reg(mem_write_reg), .mem_rd(mem_rd), .branch_taken(branch_taken),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .halted(halted), .stall_count(stall_count)
   );
   always #5 clk = ~clk;
   // stall cycles demanded by the decode instruction, straight from the hazard rules
   function automatic int ref_need(input bit v, input logic [3:0] op, input logic [2:0] c,
                                   input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] exop,
                                   input bit exw, input logic [3:0] exrd, input bit mw, input logic [3:0] mrd);
      int n = 0;
      if (!v) return 0;
      if (op == BR && exw && exrd != 0 && exrd == rs) n = 2;
      if (op == BR && mw && mrd != 0 && mrd == rs && n < 1) n = 1;
      if (exop == LW && exrd != 0 && (exrd == rs || exrd == rt) && op != BR && op != B && n < 1) n = 1;
`ifdef FLAG_STALL_EN
      if ((op == B || op == BR) && c != 3'b111 && exop inside {ADD, SUB, XOR, SLL, SRA, ROR} && n < 1) n = 1;
`else
      if (c == 3'b000 && 1'b0) n = 1;
`endif
      return n;
   endfunction
   task automatic cyc(input bit v, input logic [3:0] op, input logic [2:0] c, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] exop, input bit exw, input logic [3:0] exrd,
                      input bit mw, input logic [3:0] mrd, input bit bt);
      exp_t e;
      int n;
      id_valid = v; id_opcode = op; id_cond = c; id_rs = rs; id_rt = rt;
      ex_opcode = exop; ex_write_reg = exw; ex_rd = exrd;
      mem_write_reg = mw; mem_rd = mrd; branch_taken = bt;
      n = ref_need(v, op, c, rs, rt, exop, exw, exrd, mw, mrd);
      e.cnt = 4'(m_cnt);
      if (m_halted) e.ctl = 5'b00011;
      else if (m_drain_left > 0) begin
         e.ctl = 5'b00010;
         m_drain_left--;
         m_halted = m_drain_left == 0;
      end else if (m_stall_left > 0 || n > 0) begin
         e.ctl = 5'b00010;
         m_cnt = m_cnt == SAT ? SAT : m_cnt + 1;
         if (m_stall_left > 0) m_stall_left--;
         else if (n == 2) m_stall_left = 1;
      end else if (bt) e.ctl = 5'b11100;
      else if (v && op == HLT) begin
         e.ctl = 5'b01100;
         m_drain_left = DRAIN;
      end else e.ctl = 5'b11000;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      cyc(0, ADD, 0, 0, 0, SW, 0, 0, 0, 0, 0);
   endtask
   // reset is raised mid-cycle so it also exercises the asynchronous path
   task automatic rst_pulse();
      exp_t e;
      rst = 1;
      id_valid = 0; branch_taken = 0; ex_write_reg = 0; mem_write_reg = 0; ex_opcode = SW;
      m_stall_left = 0; m_drain_left = 0; m_halted = 0; m_cnt = 0;
      e.ctl = 5'b11000;
      e.cnt = 0;
      q.push_back(e);
      #6;
      rst = 0;
      @(posedge clk);
      #1;
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_we, ifid_we, ifid_flush, idex_bubble, halted} !== e.ctl) begin
               errors++;
               $display("FAIL ctl t=%0t got pc/ifid/flush/bubble/halted=%b want %b", $time,
                        {pc_we, ifid_we, ifid_flush, idex_bubble, halted}, e.ctl);
            end
            checks++;
            if (stall_count !== e.cnt) begin
               errors++;
               $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, e.cnt);
            end
         end
      end
   end
   initial begin
      logic [3:0] ops[12] = '{ADD, SUB, XOR, SLL, SRA, ROR, LW, SW, B, BR, BR, LW};
      logic [3:0] op;
      @(posedge clk);
      #1;
      rst_pulse();
      cyc(1, ADD, 0, 3, 5, LW, 1, 3, 0, 0, 0);
      cyc(1, ADD, 0, 3, 5, SW, 0, 0, 0, 0, 0);
      cyc(1, BR, 7, 2, 0, ADD, 1, 2, 0, 0, 1);
      cyc(1, BR, 7, 2, 0, ADD, 1, 2, 0, 0, 1);
      cyc(1, BR, 7, 2, 0, SW, 0, 0, 0, 0, 1);
      cyc(1, BR, 7, 7, 0, SW, 0, 0, 1, 7, 0);
      cyc(1, BR, 7, 0, 0, ADD, 1, 0, 1, 0, 0);
      cyc(1, B, 3'b001, 0, 0, SUB, 1, 1, 0, 0, 0);
      cyc(1, B, 3'b111, 0, 0, SUB, 1, 1, 0, 0, 0);
      cyc(0, BR, 7, 2, 0, ADD, 1, 2, 0, 0, 0);
      cyc(1, HLT, 0, 0, 0, SW, 0, 0, 0, 0, 0);
      repeat (6) idle();
      rst_pulse();
      cyc(1, BR, 7, 4, 0, ADD, 1, 4, 0, 0, 0);
      rst_pulse();
      cyc(1, HLT, 0, 0, 0, SW, 0, 0, 0, 0, 0);
      idle();
      rst_pulse();
      repeat (20) cyc(1, ADD, 0, 1, 1, LW, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) rst_pulse();
         else begin
            op = $urandom_range(0, 59) == 0 ? HLT : ops[$urandom_range(0, 11)];
            cyc($urandom_range(0, 7) != 0, op, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)), ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                $urandom_range(0, 5) == 0);
         end
      end
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending entries want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
